// File: rtl/ps2_host_tx_if.sv
// Command handshake between the host-side controller and the PS/2 transmitter.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard
// over the shared open-drain clock/data lines and reports done or error.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus released, ready for a command byte
// INHIBIT   | hold PS2_CLK low; start bit driven in the last cycle
// REQ       | clock released, data held low, wait for first device edge
// SEND      | drive data/parity/stop on device falling edges
// ACK       | data released, sample device ACK on edge 11
// WAITIDLE  | wait for clock and data both high
// ERR       | release lines, pulse tx_error
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int FIRST_TIMEOUT  = 1500000,
    parameter int EDGE_TIMEOUT   = 200000,
    parameter int FILTER_LEN     = 4
) (
    input  logic            clk,
    input  logic            rst,
    ps2_host_tx_if.slave    bus,
    input  logic            ps2_clk_in,
    input  logic            ps2_data_in,
    output logic            ps2_clk_oe,
    output logic            ps2_data_oe,
    output logic            rx_inhibit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAITIDLE,
        S_ERR
    } state_t;

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [INH_W-1:0] INH_TC   = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_TC   = FLT_W'(FILTER_LEN - 1);
    // Timeouts fire on the last cycle of the allowed window, so the error
    // pulse lands exactly TIMEOUT cycles after the window opened.
    localparam logic [20:0]      FIRST_TC = 21'(FIRST_TIMEOUT - 1);
    localparam logic [20:0]      EDGE_TC  = 21'(EDGE_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [1:0]         clk_sync, data_sync;
    logic               clk_s, data_s;
    logic               clk_filt;
    logic [FLT_W-1:0]   flt_cnt;
    logic               fall;
    logic [8:0]         shreg, shreg_nxt;
    logic [3:0]         bitcnt, bitcnt_nxt;
    logic [INH_W-1:0]   inh_cnt, inh_nxt;
    logic [20:0]        tmo, tmo_nxt;
    logic               data_oe_nxt;
    logic               done_nxt;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    // A level is accepted on the edge that takes the FILTER_LEN-th
    // consecutive differing sample; a fall is that acceptance from high.
    assign fall   = clk_filt && !clk_s && (flt_cnt == FLT_TC);

    // Two-flop synchronisers for the asynchronous pad inputs (idle high).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // Clock deglitch: level follows the synced input after a stable run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_s == clk_filt) begin
            flt_cnt  <= '0;
        end else if (flt_cnt == FLT_TC) begin
            clk_filt <= clk_s;
            flt_cnt  <= '0;
        end else begin
            flt_cnt  <= flt_cnt + 1'b1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bitcnt_nxt  = bitcnt;
        inh_nxt     = inh_cnt;
        data_oe_nxt = ps2_data_oe;
        done_nxt    = 1'b0;
        unique case (state)
            S_IDLE: begin
                data_oe_nxt = 1'b0;
                if (bus.tx_valid) begin
                    shreg_nxt   = {~^bus.tx_data, bus.tx_data};
                    bitcnt_nxt  = 4'd0;
                    inh_nxt     = INH_TC;
                    state_nxt   = S_INHIBIT;
                    data_oe_nxt = (INH_TC == '0);
                end
            end
            S_INHIBIT: begin
                if (inh_cnt == '0) begin
                    state_nxt   = S_REQ;
                    data_oe_nxt = 1'b1;
                end else begin
                    inh_nxt     = inh_cnt - 1'b1;
                    data_oe_nxt = (inh_cnt == INH_W'(1));
                end
            end
            S_REQ: begin
                data_oe_nxt = 1'b1;
                if (fall) begin
                    data_oe_nxt = ~shreg[0];
                    shreg_nxt   = {1'b0, shreg[8:1]};
                    bitcnt_nxt  = 4'd1;
                    state_nxt   = S_SEND;
                end else if (tmo == FIRST_TC) begin
                    state_nxt   = S_ERR;
                end
            end
            S_SEND: begin
                if (fall) begin
                    if (bitcnt == 4'd9) begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = S_ACK;
                    end else begin
                        data_oe_nxt = ~shreg[0];
                        shreg_nxt   = {1'b0, shreg[8:1]};
                        bitcnt_nxt  = bitcnt + 4'd1;
                    end
                end else if (tmo == EDGE_TC) begin
                    state_nxt = S_ERR;
                end
            end
            S_ACK: begin
                data_oe_nxt = 1'b0;
                if (fall) begin
                    state_nxt = data_s ? S_ERR : S_WAITIDLE;
                end else if (tmo == EDGE_TC) begin
                    state_nxt = S_ERR;
                end
            end
            S_WAITIDLE: begin
                data_oe_nxt = 1'b0;
                if (clk_filt && data_s) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tmo == EDGE_TC) begin
                    state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                data_oe_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end
            default: begin
                data_oe_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end
        endcase

        if (state_nxt == S_ERR || state_nxt == S_IDLE) begin
            data_oe_nxt = 1'b0;
        end

        // tmo restarts on any state change and on every device edge.
        if (state_nxt != state || fall) begin
            tmo_nxt = '0;
        end else if (state == S_REQ || state == S_SEND ||
                     state == S_ACK || state == S_WAITIDLE) begin
            tmo_nxt = tmo + 21'd1;
        end else begin
            tmo_nxt = '0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            shreg        <= '0;
            bitcnt       <= '0;
            inh_cnt      <= '0;
            tmo          <= '0;
            ps2_clk_oe   <= 1'b0;
            ps2_data_oe  <= 1'b0;
            rx_inhibit   <= 1'b0;
            bus.tx_ready <= 1'b1;
            bus.tx_done  <= 1'b0;
            bus.tx_error <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            bitcnt       <= bitcnt_nxt;
            inh_cnt      <= inh_nxt;
            tmo          <= tmo_nxt;
            ps2_clk_oe   <= (state_nxt == S_INHIBIT);
            ps2_data_oe  <= data_oe_nxt;
            rx_inhibit   <= (state_nxt != S_IDLE);
            bus.tx_ready <= (state_nxt == S_IDLE);
            bus.tx_done  <= done_nxt;
            bus.tx_error <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

    localparam int IC   = 20;
    localparam int FT   = 300;
    localparam int ET   = 150;
    localparam int FL   = 4;
    localparam int LOW  = 12;
    localparam int HIGH = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk_oe, ps2_data_oe, rx_inhibit;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic clk_line, data_line;

    int n_vec    = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    // Open-drain wired-AND of host and device on each line.
    assign clk_line  = dev_clk  & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (IC),
        .FIRST_TIMEOUT  (FT),
        .EDGE_TIMEOUT   (ET),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_inhibit  (rx_inhibit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame as seen by the device: data LSB first, odd parity, stop.
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = d[i];
            if (d[i]) ones++;
        end
        f[8] = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[9] = 1'b1;
        return f;
    endfunction

    // Pulse counters and done/error exclusivity.
    always @(negedge clk) begin
        if (bus.tx_done)  done_cnt++;
        if (bus.tx_error) err_cnt++;
        chk("pulse_excl", 32'(bus.tx_done & bus.tx_error), 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("ready", 32'(bus.tx_ready), 1);
    endtask

    task automatic start_tx(input logic [7:0] d);
        wait_ready();
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    task automatic inhibit_phase();
        int n, nd;
        n  = 0;
        nd = 0;
        while (ps2_clk_oe && n < IC + 50) begin
            n++;
            if (ps2_data_oe) nd++;
            @(negedge clk);
        end
        chk("inh_len", n, IC);
        chk("inh_start_cycles", nd, 1);
        chk("start_bit", 32'(data_line), 0);
    endtask

    task automatic dev_pulse();
        dev_clk = 1'b0;
        repeat (LOW) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HIGH) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit mid_valid);
        int d0, e0, n;
        logic [9:0] got;
        logic [9:0] want;
        d0   = done_cnt;
        e0   = err_cnt;
        want = exp_frame(d);
        start_tx(d);
        inhibit_phase();
        repeat ($urandom_range(5, 60)) @(negedge clk);
        for (int e = 1; e <= 10; e++) begin
            dev_clk = 1'b0;
            repeat (LOW) @(negedge clk);
            got[e-1] = data_line;
            dev_clk = 1'b1;
            bus.tx_valid = mid_valid && (e == 3);
            bus.tx_data  = 8'($urandom);
            @(negedge clk);
            bus.tx_valid = 1'b0;
            repeat (HIGH - 1) @(negedge clk);
        end
        chk("frame_bits", 32'(got), 32'(want));
        chk("parity_bit", 32'(got[8]), 32'(want[8]));
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (4) @(negedge clk);
        dev_clk = 1'b0;
        repeat (LOW) @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - d0, ack ? 1 : 0);
        chk("error_pulses", err_cnt - e0, ack ? 0 : 1);
        chk("inhibit_after", 32'(rx_inhibit), 0);
        chk("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        if (mid_valid) begin
            repeat (10) @(negedge clk);
            chk("no_queue", 32'(ps2_clk_oe), 0);
        end
    endtask

    task automatic no_clock_test();
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'($urandom));
        inhibit_phase();
        n = 0;
        while (!bus.tx_error && n < FT + 50) begin
            @(negedge clk);
            n++;
        end
        chk("first_timeout", n, FT);
        wait_ready();
        chk("ft_error_pulses", err_cnt - e0, 1);
        chk("ft_done_pulses", done_cnt - d0, 0);
        chk("ft_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    endtask

    // Device stalls after edge 5; a short clock glitch during the stall
    // must not count as an edge. Error is due ET cycles after the edge is
    // recognised: two synchroniser stages plus FL filter samples.
    task automatic edge_timeout_test();
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'($urandom));
        inhibit_phase();
        repeat (10) @(negedge clk);
        for (int e = 1; e <= 4; e++) dev_pulse();
        dev_clk = 1'b0;
        n = 0;
        while (!bus.tx_error && n < ET + 200) begin
            @(negedge clk);
            n++;
            if (n == LOW) dev_clk = 1'b1;
            if (n == 60)  dev_clk = 1'b0;
            if (n == 62)  dev_clk = 1'b1;
        end
        dev_clk = 1'b1;
        chk("edge_timeout", n, ET + 2 + FL);
        wait_ready();
        chk("et_error_pulses", err_cnt - e0, 1);
        chk("et_done_pulses", done_cnt - d0, 0);
    endtask

    task automatic reset_mid(input bit in_send);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h00);
        if (!in_send) begin
            repeat (5) @(negedge clk);
            chk("pre_rst_clk_oe", 32'(ps2_clk_oe), 1);
        end else begin
            inhibit_phase();
            repeat (10) @(negedge clk);
            dev_pulse();
            dev_pulse();
            dev_clk = 1'b0;
            repeat (LOW) @(negedge clk);
            chk("pre_rst_data_oe", 32'(ps2_data_oe), 1);
        end
        rst = 1'b0;
        #1;
        chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_data_oe", 32'(ps2_data_oe), 0);
        chk("rst_ready", 32'(bus.tx_ready), 1);
        chk("rst_inhibit", 32'(rx_inhibit), 0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        run_frame(8'($urandom), 1'b1, 1'b0);
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (5) @(negedge clk);
        chk("reset_ready", 32'(bus.tx_ready), 1);
        chk("reset_inhibit", 32'(rx_inhibit), 0);
        chk("reset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("reset_pulses", 32'({bus.tx_done, bus.tx_error}), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(8'hED, 1'b1, 1'b0);
        run_frame(8'h00, 1'b1, 1'b0);
        run_frame(8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_frame(8'($urandom), 1'b1, i == 1);
        end
        run_frame(8'($urandom), 1'b0, 1'b0);
        no_clock_test();
        edge_timeout_test();
        reset_mid(1'b0);
        reset_mid(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
